// File: rtl/wb_bram_ctrl_pkg.sv
// Shared types, widths and helpers for the Wishbone block-RAM port-A controller.
// Optional error response is enabled by WB_BRAM_CTRL_ERR_EN (see wb_bram_ctrl.sv).
package wb_bram_ctrl_pkg;

  localparam int unsigned WB_DW = 32;
  localparam int unsigned WB_SW = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WAIT,
    ST_WR,
    ST_ACK
  } state_t;

  // Bus request captured when a cycle is accepted
  typedef struct packed {
    logic             we;
    logic [WB_SW-1:0] sel;
    logic [WB_DW-1:0] dat;
  } wb_req_t;

  function automatic int unsigned log2_ceil(input int unsigned v);
    int unsigned r = 0;
    for (int unsigned i = 0; i < 31; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Lane index needs at least one bit even when a RAM word is a single lane
  function automatic int unsigned lane_width(input int unsigned ratio);
    return (log2_ceil(ratio) == 0) ? 1 : log2_ceil(ratio);
  endfunction

endpackage

// File: rtl/wb_bram_lane_merge.sv
// Combinational merge of a 32-bit bus write into one lane of a RAM word,
// replacing only the bytes whose select bit is set.
module wb_bram_lane_merge
  import wb_bram_ctrl_pkg::*;
#(
  parameter int unsigned RAM_WIDTH = 32,
  localparam int unsigned RATIO    = RAM_WIDTH / WB_DW,
  localparam int unsigned LANE_W   = lane_width(RATIO)
) (
  input  logic [RAM_WIDTH-1:0] word,
  input  logic [LANE_W-1:0]    lane,
  input  logic [WB_SW-1:0]     sel,
  input  logic [WB_DW-1:0]     data,
  output logic [RAM_WIDTH-1:0] merged_c
);

  for (genvar k = 0; k < RATIO; k++) begin : g_lane
    for (genvar b = 0; b < WB_SW; b++) begin : g_byte
      assign merged_c[k*WB_DW + b*8 +: 8] = (lane == LANE_W'(k) && sel[b])
                                            ? data[b*8 +: 8]
                                            : word[k*WB_DW + b*8 +: 8];
    end
  end

endmodule

// File: rtl/wb_bram_ctrl.sv
// Wishbone classic slave driving port A of a dual-port block RAM, with RMW for partial writes.
// Define WB_BRAM_CTRL_ERR_EN to error-acknowledge out-of-range addresses instead of wrapping.
module wb_bram_ctrl
  import wb_bram_ctrl_pkg::*;
#(
  parameter int unsigned RAM_WIDTH     = 32,
  parameter int unsigned RAM_ADDRWIDTH = 10,
  parameter int unsigned RAM_DEPTH     = 1024,
  parameter int unsigned RAM_LATENCY   = 2
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic                     wb_cyc_i,
  input  logic                     wb_stb_i,
  input  logic                     wb_we_i,
  input  logic [WB_SW-1:0]         wb_sel_i,
  input  logic [31:0]              wb_adr_i,
  input  logic [WB_DW-1:0]         wb_dat_i,
  output logic [WB_DW-1:0]         wb_dat_o,
  output logic                     wb_ack_o,
  output logic                     wb_err_o,
  output logic                     ram_en,
  output logic                     ram_we,
  output logic [RAM_ADDRWIDTH-1:0] ram_addr,
  output logic [RAM_WIDTH-1:0]     ram_din,
  input  logic [RAM_WIDTH-1:0]     ram_dout
);

  localparam int unsigned RATIO    = RAM_WIDTH / WB_DW;
  localparam int unsigned SEL_BITS = log2_ceil(RATIO);
  localparam int unsigned LANE_W   = lane_width(RATIO);
  localparam int unsigned CNT_W    = log2_ceil(RAM_LATENCY) + 1;
  localparam int unsigned WORD_LSB = 2 + SEL_BITS;

  if (RAM_LATENCY == 0 || 64'(RAM_DEPTH) > (64'd1 << RAM_ADDRWIDTH)) begin : g_bad_cfg
    $error("wb_bram_ctrl: unsupported RAM_LATENCY or RAM_DEPTH");
  end

  state_t                   state;
  logic [CNT_W-1:0]         cnt;
  wb_req_t                  req;
  logic [LANE_W-1:0]        req_lane;
  logic                     err_q;

  logic [LANE_W-1:0]        lane_c;
  logic [RAM_ADDRWIDTH-1:0] word_c;
  logic                     addr_err_c;
  logic                     full_wr_c;
  logic [RAM_WIDTH-1:0]     merged_c;
  logic [WB_DW-1:0]         rd_lane_c;
  logic                     unused_c;

  assign lane_c    = LANE_W'((wb_adr_i >> 2) & WB_DW'(RATIO - 1));
  assign word_c    = RAM_ADDRWIDTH'(wb_adr_i >> WORD_LSB);
  assign full_wr_c = (RATIO == 1) && wb_we_i && (wb_sel_i == {WB_SW{1'b1}});

`ifdef WB_BRAM_CTRL_ERR_EN
  localparam int unsigned TOP_LSB = WORD_LSB + RAM_ADDRWIDTH;
  assign addr_err_c = (WB_DW'(word_c) >= WB_DW'(RAM_DEPTH)) || ((wb_adr_i >> TOP_LSB) != '0);
  assign wb_err_o   = err_q;
`else
  assign addr_err_c = 1'b0;
  assign wb_err_o   = 1'b0;
`endif

  // Byte-address low bits never select anything; upper bits only matter for error checks
  assign unused_c = ^{wb_adr_i, err_q};

  // Lane select of the RAM read word, built as an AND-OR chain
  logic [RATIO:0][WB_DW-1:0] rd_acc;
  assign rd_acc[0] = '0;
  for (genvar k = 0; k < RATIO; k++) begin : g_rd
    assign rd_acc[k+1] = rd_acc[k] | ((req_lane == LANE_W'(k)) ? ram_dout[k*WB_DW +: WB_DW] : '0);
  end
  assign rd_lane_c = rd_acc[RATIO];

  wb_bram_lane_merge #(
    .RAM_WIDTH(RAM_WIDTH)
  ) u_merge (
    .word    (ram_dout),
    .lane    (req_lane),
    .sel     (req.sel),
    .data    (req.dat),
    .merged_c(merged_c)
  );

  // Controller FSM; single-cycle strobes default low each clock
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      req      <= '0;
      req_lane <= '0;
      err_q    <= 1'b0;
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
      ram_en   <= 1'b0;
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_din  <= '0;
    end else begin
      wb_ack_o <= 1'b0;
      err_q    <= 1'b0;
      ram_en   <= 1'b0;
      ram_we   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (wb_cyc_i && wb_stb_i) begin
            req      <= '{we: wb_we_i, sel: wb_sel_i, dat: wb_dat_i};
            req_lane <= lane_c;
            ram_addr <= word_c;
            if (addr_err_c) begin
              err_q <= 1'b1;
              state <= ST_ACK;
            end else if (full_wr_c) begin
              ram_en  <= 1'b1;
              ram_we  <= 1'b1;
              ram_din <= RAM_WIDTH'(wb_dat_i);
              state   <= ST_WR;
            end else begin
              ram_en <= 1'b1;
              state  <= ST_RD;
            end
          end
        end
        ST_RD: begin
          if (!wb_cyc_i) begin
            state <= ST_IDLE;
          end else begin
            cnt   <= CNT_W'(RAM_LATENCY - 1);
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!wb_cyc_i) begin
            state <= ST_IDLE;
          end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else if (req.we) begin
            // An all-zero byte select still walks the RMW path but never touches the RAM
            ram_din <= merged_c;
            ram_en  <= |req.sel;
            ram_we  <= |req.sel;
            state   <= ST_WR;
          end else begin
            wb_dat_o <= rd_lane_c;
            wb_ack_o <= 1'b1;
            state    <= ST_ACK;
          end
        end
        ST_WR: begin
          if (!wb_cyc_i) begin
            state <= ST_IDLE;
          end else begin
            wb_ack_o <= 1'b1;
            state    <= ST_ACK;
          end
        end
        ST_ACK: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_bram_ctrl.sv
// Directed bench for wb_bram_ctrl: a 64-bit (depth 1000) and a 32-bit instance, each with a latency-2 RAM model.
// Expectations for out-of-range addresses follow WB_BRAM_CTRL_ERR_EN.
module tb_wb_bram_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        cyc64, cyc32, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat;

  logic [31:0] dat64, dat32;
  logic        ack64, ack32, err64, err32;
  logic        en64, en32, we64, we32;
  logic [9:0]  addr64, addr32;
  logic [63:0] din64, dout64;
  logic [31:0] din32, dout32;

  logic        ld_en;
  logic [9:0]  ld_addr;
  logic [63:0] ld_data;

  int total = 0;
  int bad   = 0;

  wb_bram_ctrl #(
    .RAM_WIDTH(64), .RAM_ADDRWIDTH(10), .RAM_DEPTH(1000), .RAM_LATENCY(2)
  ) dut64 (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_cyc_i(cyc64), .wb_stb_i(stb), .wb_we_i(we),
    .wb_sel_i(sel), .wb_adr_i(adr), .wb_dat_i(dat), .wb_dat_o(dat64), .wb_ack_o(ack64),
    .wb_err_o(err64), .ram_en(en64), .ram_we(we64), .ram_addr(addr64), .ram_din(din64),
    .ram_dout(dout64)
  );

  wb_bram_ctrl #(
    .RAM_WIDTH(32), .RAM_ADDRWIDTH(10), .RAM_DEPTH(1024), .RAM_LATENCY(2)
  ) dut32 (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_cyc_i(cyc32), .wb_stb_i(stb), .wb_we_i(we),
    .wb_sel_i(sel), .wb_adr_i(adr), .wb_dat_i(dat), .wb_dat_o(dat32), .wb_ack_o(ack32),
    .wb_err_o(err32), .ram_en(en32), .ram_we(we32), .ram_addr(addr32), .ram_din(din32),
    .ram_dout(dout32)
  );

  // RAM models: data registered at the enable edge, then one output register
  logic [63:0] mem64 [0:1023];
  logic [31:0] mem32 [0:1023];
  logic [63:0] s64;
  logic [31:0] s32;

  always @(posedge clk) begin
    if (ld_en) mem64[ld_addr] <= ld_data;
    else if (en64 && we64) mem64[addr64] <= din64;
    if (en64 && !we64) s64 <= mem64[addr64];
    dout64 <= s64;
  end

  always @(posedge clk) begin
    if (en32 && we32) mem32[addr32] <= din32;
    if (en32 && !we32) s32 <= mem32[addr32];
    dout32 <= s32;
  end

  // Output view of the instance currently addressed
  int          tgt = 64;
  logic        o_ack, o_err, o_en, o_we;
  logic [9:0]  o_addr;
  logic [63:0] o_din;
  logic [31:0] o_dat;

  always_comb begin
    if (tgt == 64) begin
      o_ack = ack64; o_err = err64; o_en = en64; o_we = we64;
      o_addr = addr64; o_din = din64; o_dat = dat64;
    end else begin
      o_ack = ack32; o_err = err32; o_en = en32; o_we = we32;
      o_addr = addr32; o_din = {32'd0, din32}; o_dat = dat32;
    end
  end

  int          r_ack, r_err, r_we, r_en;
  logic [9:0]  r_addr;
  logic [63:0] r_din;
  logic [31:0] r_dat;

  task automatic preload(input logic [9:0] a, input logic [63:0] d);
    ld_addr = a; ld_data = d; ld_en = 1'b1;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  // One bus transaction; records ack/err/write cycle numbers (stb raised in cycle 0)
  task automatic txn(input int t, input logic w, input logic [31:0] a, input logic [3:0] s,
                     input logic [31:0] d, input int drop_at);
    tgt = t; we = w; adr = a; sel = s; dat = d; stb = 1'b1;
    if (t == 64) cyc64 = 1'b1; else cyc32 = 1'b1;
    r_ack = -1; r_err = -1; r_we = -1; r_en = 0; r_addr = '0; r_din = '0; r_dat = '0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (o_ack && r_ack < 0) begin r_ack = c; r_dat = o_dat; end
      if (o_err && r_err < 0) r_err = c;
      if (o_en) begin r_en++; r_addr = o_addr; end
      if (o_en && o_we && r_we < 0) begin r_we = c; r_din = o_din; end
      if (c == drop_at) begin cyc64 = 1'b0; cyc32 = 1'b0; stb = 1'b0; end
      if (drop_at < 0 && (r_ack >= 0 || r_err >= 0)) break;
    end
    cyc64 = 1'b0; cyc32 = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    total++; if ({ack64, err64, en64, we64} !== 4'b0) begin bad++; $display("FAIL por_ctl64 got=%b want=0000", {ack64, err64, en64, we64}); end
    total++; if ({ack32, err32, en32, we32} !== 4'b0) begin bad++; $display("FAIL por_ctl32 got=%b want=0000", {ack32, err32, en32, we32}); end
    total++; if (dat64 !== 32'h0) begin bad++; $display("FAIL por_dat64 got=%h want=0", dat64); end
    preload(10'd2, 64'hCAFEF00D_0BADBEEF);
    txn(64, 1'b0, 32'h10, 4'hF, 32'h0, -1);
    total++; if (r_ack !== 4) begin bad++; $display("FAIL pre_rd_ack got=%0d want=4", r_ack); end
    total++; if (r_dat !== 32'h0BADBEEF) begin bad++; $display("FAIL pre_rd_dat got=%h want=0badbeef", r_dat); end
    // Reset asserted while the read is waiting on RAM latency
    tgt = 64; we = 1'b0; adr = 32'h14; sel = 4'hF; stb = 1'b1; cyc64 = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      total++;
      if ({ack64, err64, en64, we64} !== 4'b0 || dat64 !== 32'h0) begin
        bad++; $display("FAIL mid_rst%0d got=%b/%h want=0000/0", i, {ack64, err64, en64, we64}, dat64);
      end
    end
    rst = 1'b0; cyc64 = 1'b0; stb = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      total++; if (ack64 !== 1'b0) begin bad++; $display("FAIL post_rst_ack got=%b want=0", ack64); end
    end
    txn(64, 1'b0, 32'h14, 4'hF, 32'h0, -1);
    total++; if (r_ack !== 4) begin bad++; $display("FAIL rst_rd_ack got=%0d want=4", r_ack); end
    total++; if (r_dat !== 32'hCAFEF00D) begin bad++; $display("FAIL rst_rd_dat got=%h want=cafef00d", r_dat); end
  endtask

  task automatic test_full_write();
    txn(32, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, -1);
    total++; if (r_we !== 1) begin bad++; $display("FAIL fw_we_cyc got=%0d want=1", r_we); end
    total++; if (r_addr !== 10'd4) begin bad++; $display("FAIL fw_addr got=%0d want=4", r_addr); end
    total++; if (r_ack !== 2) begin bad++; $display("FAIL fw_ack got=%0d want=2", r_ack); end
    total++; if (r_din !== 64'hDEADBEEF) begin bad++; $display("FAIL fw_din got=%h want=deadbeef", r_din); end
    total++; if (r_en !== 1) begin bad++; $display("FAIL fw_en_cnt got=%0d want=1", r_en); end
    txn(32, 1'b0, 32'h10, 4'hF, 32'h0, -1);
    total++; if (r_ack !== 4) begin bad++; $display("FAIL fw_rd_ack got=%0d want=4", r_ack); end
    total++; if (r_dat !== 32'hDEADBEEF) begin bad++; $display("FAIL fw_rd_dat got=%h want=deadbeef", r_dat); end
  endtask

  task automatic test_rmw_lane();
    preload(10'd0, 64'hAAAAAAAA_BBBBBBBB);
    txn(64, 1'b1, 32'h4, 4'hF, 32'h11223344, -1);
    total++; if (r_din !== 64'h11223344_BBBBBBBB) begin bad++; $display("FAIL rmw_din got=%h want=11223344bbbbbbbb", r_din); end
    total++; if (r_ack !== 5) begin bad++; $display("FAIL rmw_ack got=%0d want=5", r_ack); end
    total++; if (r_we !== 4) begin bad++; $display("FAIL rmw_we_cyc got=%0d want=4", r_we); end
    total++; if (r_en !== 2) begin bad++; $display("FAIL rmw_en_cnt got=%0d want=2", r_en); end
    txn(64, 1'b0, 32'h4, 4'hF, 32'h0, -1);
    total++; if (r_dat !== 32'h11223344) begin bad++; $display("FAIL rmw_rd1 got=%h want=11223344", r_dat); end
    txn(64, 1'b0, 32'h0, 4'hF, 32'h0, -1);
    total++; if (r_dat !== 32'hBBBBBBBB) begin bad++; $display("FAIL rmw_rd0 got=%h want=bbbbbbbb", r_dat); end
  endtask

  task automatic test_byte_sel();
    preload(10'd0, 64'h9ABCDEF0_12345678);
    txn(64, 1'b1, 32'h0, 4'b0010, 32'h0000CD00, -1);
    total++; if (r_din !== 64'h9ABCDEF0_1234CD78) begin bad++; $display("FAIL bsel_din got=%h want=9abcdef01234cd78", r_din); end
    total++; if (r_ack !== 5) begin bad++; $display("FAIL bsel_ack got=%0d want=5", r_ack); end
    txn(64, 1'b0, 32'h0, 4'hF, 32'h0, -1);
    total++; if (r_dat !== 32'h1234CD78) begin bad++; $display("FAIL bsel_rd0 got=%h want=1234cd78", r_dat); end
    txn(64, 1'b0, 32'h4, 4'hF, 32'h0, -1);
    total++; if (r_dat !== 32'h9ABCDEF0) begin bad++; $display("FAIL bsel_rd1 got=%h want=9abcdef0", r_dat); end
  endtask

  task automatic test_abort();
    preload(10'd1, 64'h77777777_66666666);
    txn(64, 1'b0, 32'h8, 4'hF, 32'h0, 2);
    total++; if (r_ack !== -1) begin bad++; $display("FAIL abort_ack got=%0d want=-1", r_ack); end
    total++; if (r_we !== -1) begin bad++; $display("FAIL abort_we got=%0d want=-1", r_we); end
    total++; if (r_en !== 1) begin bad++; $display("FAIL abort_en_cnt got=%0d want=1", r_en); end
    txn(64, 1'b1, 32'h8, 4'hF, 32'h5, -1);
    total++; if (r_ack !== 5) begin bad++; $display("FAIL abort_wr_ack got=%0d want=5", r_ack); end
    total++; if (r_din !== 64'h77777777_00000005) begin bad++; $display("FAIL abort_wr_din got=%h want=7777777700000005", r_din); end
    // All-zero byte select: no RAM write, acknowledged at RMW time
    txn(64, 1'b1, 32'h8, 4'h0, 32'hFFFFFFFF, -1);
    total++; if (r_ack !== 5) begin bad++; $display("FAIL sel0_ack got=%0d want=5", r_ack); end
    total++; if (r_we !== -1) begin bad++; $display("FAIL sel0_we got=%0d want=-1", r_we); end
    // cyc dropped during the write cycle: write lands, no ack
    txn(64, 1'b1, 32'hC, 4'hF, 32'hFEEDFACE, 4);
    total++; if (r_we !== 4) begin bad++; $display("FAIL wrdrop_we got=%0d want=4", r_we); end
    total++; if (r_ack !== -1) begin bad++; $display("FAIL wrdrop_ack got=%0d want=-1", r_ack); end
    txn(64, 1'b0, 32'hC, 4'hF, 32'h0, -1);
    total++; if (r_dat !== 32'hFEEDFACE) begin bad++; $display("FAIL wrdrop_rd got=%h want=feedface", r_dat); end
    txn(64, 1'b0, 32'h8, 4'hF, 32'h0, -1);
    total++; if (r_dat !== 32'h00000005) begin bad++; $display("FAIL sel0_rd got=%h want=5", r_dat); end
  endtask

  task automatic test_range();
`ifdef WB_BRAM_CTRL_ERR_EN
    txn(64, 1'b0, 32'h2000, 4'hF, 32'h0, -1);
    total++; if (r_err !== 1) begin bad++; $display("FAIL rng1024_err got=%0d want=1", r_err); end
    total++; if (r_ack !== -1) begin bad++; $display("FAIL rng1024_ack got=%0d want=-1", r_ack); end
    total++; if (r_en !== 0) begin bad++; $display("FAIL rng1024_en got=%0d want=0", r_en); end
    txn(64, 1'b1, 32'h1F40, 4'hF, 32'h1, -1);
    total++; if (r_err !== 1) begin bad++; $display("FAIL rng1000_err got=%0d want=1", r_err); end
    total++; if (r_en !== 0) begin bad++; $display("FAIL rng1000_en got=%0d want=0", r_en); end
    txn(64, 1'b0, 32'h8000_0000, 4'hF, 32'h0, -1);
    total++; if (r_err !== 1) begin bad++; $display("FAIL rng_top_err got=%0d want=1", r_err); end
    txn(64, 1'b0, 32'h1F38, 4'hF, 32'h0, -1);
    total++; if (r_ack !== 4 || r_err !== -1) begin bad++; $display("FAIL rng999 got=ack%0d/err%0d want=ack4/err-1", r_ack, r_err); end
`else
    txn(64, 1'b0, 32'h2000, 4'hF, 32'h0, -1);
    total++; if (r_ack !== 4) begin bad++; $display("FAIL wrap_ack got=%0d want=4", r_ack); end
    total++; if (r_addr !== 10'd0) begin bad++; $display("FAIL wrap_addr got=%0d want=0", r_addr); end
    total++; if (r_dat !== 32'h1234CD78) begin bad++; $display("FAIL wrap_dat got=%h want=1234cd78", r_dat); end
    total++; if (r_err !== -1) begin bad++; $display("FAIL wrap_err got=%0d want=-1", r_err); end
    txn(64, 1'b0, 32'h1F40, 4'hF, 32'h0, -1);
    total++; if (r_ack !== 4) begin bad++; $display("FAIL idx1000_ack got=%0d want=4", r_ack); end
    total++; if (r_addr !== 10'd1000) begin bad++; $display("FAIL idx1000_addr got=%0d want=1000", r_addr); end
`endif
  endtask

  initial begin
    rst = 1'b1; cyc64 = 1'b0; cyc32 = 1'b0; stb = 1'b0; we = 1'b0;
    sel = 4'h0; adr = '0; dat = '0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    test_reset();
    test_full_write();
    test_rmw_lane();
    test_byte_sel();
    test_abort();
    test_range();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

endmodule
